// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter/sequencer that shares one I2C byte master among NUM_REQ
// requesters. It latches the winner's address, R/W flag and write byte, drives the
// master's enable/addr/rw/data interface, and returns the read byte with a done pulse.
// Optional build macro: I2C_ARB_TIMEOUT_EN adds an ISSUE/BUSY watchdog that aborts
// the transaction with err alongside done.
//
// Handshakes:
//   Client side: a requester holds req[i] and its fields. gnt[i] marks the owner from
//   the ISSUE entry edge until the DONE exit edge. done[i] is a one-cycle pulse that
//   closes the transaction. Dropping req after grant does not abort the transaction.
//   Master side: m_ready=1 means the master is idle. m_enable is raised on ISSUE entry
//   and held until the master shows it has started (m_ready=0). Completion is the
//   return of m_ready=1.
module i2c_master_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [7*NUM_REQ-1:0] req_addr,
  input  logic [NUM_REQ-1:0]   req_rw,
  input  logic [8*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   done,
  output logic [7:0]           rdata,
  output logic                 err,
  output logic                 m_enable,
  output logic [6:0]           m_addr,
  output logic                 m_rw,
  output logic [7:0]           m_wdata,
  input  logic                 m_ready,
  input  logic [7:0]           m_rdata,
  output logic [1:0]           fsm_state
);

  localparam int PW = $clog2(NUM_REQ);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_BUSY  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  // Reject unsupported configurations at elaboration time.
  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("i2c_master_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 2");
  end

  logic [1:0]    state;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] owner;
  logic [PW-1:0] winner;
  logic [PW-1:0] cand;
  logic          found;
  int            idx;
  logic [6:0]    w_addr;
  logic          w_rw;
  logic [7:0]    w_wdata;
  logic          tmo;

  assign fsm_state = state;

  // Round-robin search: first asserted req starting at rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found  = 1'b0;
    winner = rr_ptr;
    cand   = '0;
    idx    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = PW'(idx);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Select the winner's transaction fields from the packed request buses.
  always_comb begin
    w_addr  = '0;
    w_rw    = 1'b0;
    w_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == PW'(i)) begin
        w_addr  = req_addr[7*i +: 7];
        w_rw    = req_rw[i];
        w_wdata = req_wdata[8*i +: 8];
      end
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] tmo_cnt;

  assign tmo = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Watchdog: cleared while idle (so it starts from 0 on ISSUE entry), counts in ISSUE/BUSY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (state == S_IDLE) begin
      tmo_cnt <= '0;
    end else if (state == S_ISSUE || state == S_BUSY) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  // Transaction sequencer: grant, issue to master, wait for completion, report.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      gnt      <= '0;
      done     <= '0;
      err      <= 1'b0;
      rdata    <= '0;
      m_enable <= 1'b0;
      m_addr   <= '0;
      m_rw     <= 1'b0;
      m_wdata  <= '0;
    end else begin
      done <= '0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (found && m_ready) begin
            owner    <= winner;
            gnt      <= ONE_HOT0 << winner;
            m_addr   <= w_addr;
            m_rw     <= w_rw;
            m_wdata  <= w_wdata;
            m_enable <= 1'b1;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (tmo) begin
            m_enable <= 1'b0;
            done     <= ONE_HOT0 << owner;
            err      <= 1'b1;
            state    <= S_DONE;
          end else if (!m_ready) begin
            m_enable <= 1'b0;
            state    <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (tmo) begin
            done  <= ONE_HOT0 << owner;
            err   <= 1'b1;
            state <= S_DONE;
          end else if (m_ready) begin
            rdata <= m_rdata;
            done  <= ONE_HOT0 << owner;
            state <= S_DONE;
          end
        end
        default: begin
          gnt    <= '0;
          rr_ptr <= (owner == PW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule
